// File: rtl/rbus_pkg.sv
// Shared rbus definitions: word layout, header field positions and the
// output-side state encoding used by the two-lane packet buffer.
package rbus_pkg;

    localparam int RBUS_W        = 72;
    localparam int RBUS_LANE_BIT = 71;
    localparam int RBUS_LEN_LSB  = 64;
    localparam int RBUS_LEN_MSB  = 67;
    localparam int RBUS_MAX_PKT  = 9;

    // Width of the header payload-count field, and of a stored packet
    // length (header word included, so one extra bit).
    localparam int RBUS_LEN_W  = RBUS_LEN_MSB - RBUS_LEN_LSB + 1;
    localparam int RBUS_PLEN_W = RBUS_LEN_W + 1;

    typedef logic [RBUS_W-1:0] rbus_word_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_t;

    // Payload word count carried in a header word.
    function automatic logic [RBUS_LEN_W-1:0] rbus_hdr_len(input rbus_word_t w);
        return w[RBUS_LEN_MSB:RBUS_LEN_LSB];
    endfunction

endpackage

// File: rtl/rbus_lane_fifo.sv
// Single-lane word FIFO with a companion length FIFO holding the committed
// word count of every stored packet. Up to two packets can be committed in
// one cycle (a truncated packet plus a zero-payload header that closed it).
module rbus_lane_fifo
    import rbus_pkg::*;
#(
    parameter  int DEPTH   = 32,
    parameter  int MAX_PKT = RBUS_MAX_PKT,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  rbus_word_t             wr_data,
    input  logic                   push_a,
    input  logic [RBUS_PLEN_W-1:0] len_a,
    input  logic                   push_b,
    input  logic [RBUS_PLEN_W-1:0] len_b,
    input  logic                   rd_en,
    input  logic                   pop,
    output rbus_word_t             rd_data,
    output logic [RBUS_PLEN_W-1:0] head_len,
    output logic [CW-1:0]          free,
    output logic [CW-1:0]          pkt_cnt,
    output logic                   rdy,
    output logic                   empty
);

    rbus_word_t             mem     [DEPTH];
    logic [RBUS_PLEN_W-1:0] len_mem [DEPTH];

    logic [AW-1:0] wp, rp, lwp, lrp;
    logic [CW-1:0] cnt, pcnt, cnt_nxt, pcnt_nxt;

    assign rd_data  = mem[rp];
    assign head_len = len_mem[lrp];
    assign free     = CW'(DEPTH) - cnt;
    assign pkt_cnt  = pcnt;

    // Word and packet occupancy after this cycle's writes, commits and reads.
    always_comb begin
        cnt_nxt  = cnt + CW'(wr_en) - CW'(rd_en);
        pcnt_nxt = pcnt + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    // Storage arrays; the older (truncated) packet length goes in first.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wr_data;
        if (push_a) len_mem[lwp] <= len_a;
        if (push_b) len_mem[push_a ? lwp + AW'(1) : lwp] <= len_b;
    end

    // Pointers, counters and the registered readiness/empty flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            lwp   <= '0;
            lrp   <= '0;
            cnt   <= '0;
            pcnt  <= '0;
            rdy   <= 1'b1;
            empty <= 1'b1;
        end else begin
            wp    <= wp + AW'(wr_en);
            rp    <= rp + AW'(rd_en);
            lwp   <= lwp + AW'(push_a) + AW'(push_b);
            lrp   <= lrp + AW'(pop);
            cnt   <= cnt_nxt;
            pcnt  <= pcnt_nxt;
            rdy   <= (CW'(DEPTH) - cnt_nxt) >= CW'(MAX_PKT);
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/rbus_pkt_fifo2ch.sv
// Two-lane store-and-forward rbus packet buffer. Incoming packets are sorted
// into per-lane FIFOs by the header lane bit; only complete packets are sent
// downstream, one whole packet at a time, arbitrated between lanes.
//
// Handshake: upstream starts a packet on lane k only when i_rdy[k] was 1, then
// streams its words with i_stb (no backpressure inside a packet). Downstream
// readiness o_rdy[k] means lane k can take one whole packet; it is looked at
// only when choosing the next packet, never during one.
module rbus_pkt_fifo2ch
    import rbus_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int MAX_PKT = RBUS_MAX_PKT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stb,
    input  logic              i_sof,
    input  logic [RBUS_W-1:0] i_data,
    output logic [1:0]        i_rdy,
    output logic [1:0]        i_rdyE,
    output logic              o_stb,
    output logic              o_sof,
    output logic [RBUS_W-1:0] o_data,
    input  logic [1:0]        o_rdy,
    input  logic [1:0]        o_rdyE,
    output logic              ff_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = RBUS_PLEN_W;

    // Input framing state
    logic                  in_open_q, in_open_n;
    logic                  in_lane_q, in_lane_n;
    logic [RBUS_LEN_W-1:0] in_rem_q,  in_rem_n;
    logic [PW-1:0]         in_wcnt_q, in_wcnt_n;
    logic                  err_q,     err_n;

    logic          hdr_lane;
    logic [RBUS_LEN_W-1:0] hdr_len;
    logic [1:0]    wr_en, push_a, push_b;
    logic [PW-1:0] len_b;

    // Lane FIFO views
    rbus_word_t    rd_data  [2];
    logic [PW-1:0] head_len [2];
    logic [CW-1:0] free     [2];
    logic [CW-1:0] pkt_cnt  [2];
    logic [1:0]    rd_en, pop;

    // Output FSM state
    out_state_t    state_q, state_n;
    logic          sel_q,   sel_n;
    logic [PW-1:0] ocnt_q,  ocnt_n;
    logic          first_q, first_n;
    logic          rr_q,    rr_n;
    logic          o_stb_n, o_sof_n;
    rbus_word_t    o_data_n;
    logic [1:0]    elig, pref;
    logic          win;

    assign hdr_lane = i_data[RBUS_LANE_BIT];
    assign hdr_len  = rbus_hdr_len(i_data);
    assign ff_err   = err_q;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        rbus_lane_fifo #(
            .DEPTH  (DEPTH),
            .MAX_PKT(MAX_PKT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[k]),
            .wr_data (i_data),
            .push_a  (push_a[k]),
            .len_a   (in_wcnt_q),
            .push_b  (push_b[k]),
            .len_b   (len_b),
            .rd_en   (rd_en[k]),
            .pop     (pop[k]),
            .rd_data (rd_data[k]),
            .head_len(head_len[k]),
            .free    (free[k]),
            .pkt_cnt (pkt_cnt[k]),
            .rdy     (i_rdy[k]),
            .empty   (i_rdyE[k])
        );
    end

    // Input framing: route words to lanes, close packets, flag protocol errors.
    // A packet whose header was dropped keeps a word count of zero, so its
    // payload is discarded and it is never committed.
    always_comb begin
        in_open_n = in_open_q;
        in_lane_n = in_lane_q;
        in_rem_n  = in_rem_q;
        in_wcnt_n = in_wcnt_q;
        err_n     = err_q;
        wr_en     = '0;
        push_a    = '0;
        push_b    = '0;
        len_b     = '0;
        if (i_stb && i_sof) begin
            if (in_open_q) begin
                err_n = 1'b1;
                if (in_wcnt_q != '0) push_a[in_lane_q] = 1'b1;
            end
            in_wcnt_n = '0;
            if (free[hdr_lane] != '0) begin
                wr_en[hdr_lane] = 1'b1;
                in_wcnt_n       = PW'(1);
            end else begin
                err_n = 1'b1;
            end
            in_lane_n = hdr_lane;
            in_rem_n  = hdr_len;
            len_b     = in_wcnt_n;
            if (hdr_len == '0) begin
                in_open_n = 1'b0;
                if (in_wcnt_n != '0) push_b[hdr_lane] = 1'b1;
            end else begin
                in_open_n = 1'b1;
            end
        end else if (i_stb) begin
            if (!in_open_q) begin
                err_n = 1'b1;
            end else begin
                if (in_wcnt_q != '0) begin
                    if (free[in_lane_q] != '0) begin
                        wr_en[in_lane_q] = 1'b1;
                        in_wcnt_n        = in_wcnt_q + PW'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
                in_rem_n = in_rem_q - RBUS_LEN_W'(1);
                len_b    = in_wcnt_n;
                if (in_rem_q == RBUS_LEN_W'(1)) begin
                    in_open_n = 1'b0;
                    if (in_wcnt_n != '0) push_b[in_lane_q] = 1'b1;
                end
            end
        end
    end

    // Input framing registers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_open_q <= 1'b0;
            in_lane_q <= 1'b0;
            in_rem_q  <= '0;
            in_wcnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            in_open_q <= in_open_n;
            in_lane_q <= in_lane_n;
            in_rem_q  <= in_rem_n;
            in_wcnt_q <= in_wcnt_n;
            err_q     <= err_n;
        end
    end

    // Output arbitration and send sequencing. Lanes whose downstream is empty
    // are preferred; ties go to the lane after the one served last.
    always_comb begin
        state_n  = state_q;
        sel_n    = sel_q;
        ocnt_n   = ocnt_q;
        first_n  = first_q;
        rr_n     = rr_q;
        o_stb_n  = 1'b0;
        o_sof_n  = 1'b0;
        o_data_n = o_data;
        rd_en    = '0;
        pop      = '0;
        elig[0]  = (pkt_cnt[0] != '0) && o_rdy[0];
        elig[1]  = (pkt_cnt[1] != '0) && o_rdy[1];
        pref     = elig & o_rdyE;
        if (pref == 2'b00) pref = elig;
        win      = (pref == 2'b11) ? rr_q : pref[1];
        case (state_q)
            OUT_IDLE: begin
                if (pref != 2'b00) begin
                    sel_n   = win;
                    ocnt_n  = head_len[win];
                    first_n = 1'b1;
                    state_n = OUT_SEND;
                end
            end
            OUT_SEND: begin
                rd_en[sel_q] = 1'b1;
                o_stb_n      = 1'b1;
                o_sof_n      = first_q;
                o_data_n     = rd_data[sel_q];
                first_n      = 1'b0;
                ocnt_n       = ocnt_q - PW'(1);
                if (ocnt_q == PW'(1)) begin
                    pop[sel_q] = 1'b1;
                    rr_n       = ~sel_q;
                    state_n    = OUT_IDLE;
                end
            end
            default: state_n = OUT_IDLE;
        endcase
    end

    // Output FSM registers and registered output word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= OUT_IDLE;
            sel_q   <= 1'b0;
            ocnt_q  <= '0;
            first_q <= 1'b0;
            rr_q    <= 1'b0;
            o_stb   <= 1'b0;
            o_sof   <= 1'b0;
            o_data  <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            ocnt_q  <= ocnt_n;
            first_q <= first_n;
            rr_q    <= rr_n;
            o_stb   <= o_stb_n;
            o_sof   <= o_sof_n;
            o_data  <= o_data_n;
        end
    end

endmodule

// File: tb/tb_rbus_pkt_fifo2ch.sv
// Bench for the two-lane rbus packet buffer: a cycle table for a single
// packet, then scoreboarded multi-packet sequences for ordering, backpressure,
// protocol errors and reset during a send.
module tb_rbus_pkt_fifo2ch;
    import rbus_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_stb = 1'b0, i_sof = 1'b0;
    logic [71:0] i_data = '0;
    logic [1:0]  i_rdy, i_rdyE;
    logic        o_stb, o_sof;
    logic [71:0] o_data;
    logic [1:0]  o_rdy = 2'b11, o_rdyE = 2'b00;
    logic        ff_err;

    always #5 clk = ~clk;

    rbus_pkt_fifo2ch #(.DEPTH(32), .MAX_PKT(9)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_stb (i_stb),
        .i_sof (i_sof),
        .i_data(i_data),
        .i_rdy (i_rdy),
        .i_rdyE(i_rdyE),
        .o_stb (o_stb),
        .o_sof (o_sof),
        .o_data(o_data),
        .o_rdy (o_rdy),
        .o_rdyE(o_rdyE),
        .ff_err(ff_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [72:0] exp_q[$];
    logic [72:0] got_q[$];

    always @(negedge clk) begin
        if (rst === 1'b1 && o_stb === 1'b1) got_q.push_back({o_sof, o_data});
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    function automatic logic [71:0] mk_hdr(input logic lane, input logic [3:0] len, input logic [7:0] tag);
        return {lane, 3'b000, len, 56'h0, tag};
    endfunction

    function automatic logic [71:0] mk_pay(input logic [7:0] tag, input int idx);
        return {8'hC3, tag, 48'h0, 8'(idx)};
    endfunction

    task automatic do_reset();
        rst    = 1'b0;
        i_stb  = 1'b0;
        i_sof  = 1'b0;
        i_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic put(input logic stb, input logic sof, input logic [71:0] d);
        i_stb  = stb;
        i_sof  = sof;
        i_data = d;
        @(posedge clk);
        #1;
        i_stb  = 1'b0;
        i_sof  = 1'b0;
        i_data = '0;
    endtask

    task automatic send_pkt(input logic lane, input logic [3:0] len, input logic [7:0] tag, input int nsend);
        put(1'b1, 1'b1, mk_hdr(lane, len, tag));
        for (int i = 0; i < nsend; i++) put(1'b1, 1'b0, mk_pay(tag, i));
    endtask

    task automatic exp_pkt(input logic lane, input logic [3:0] len, input logic [7:0] tag, input int nsend);
        exp_q.push_back({1'b1, mk_hdr(lane, len, tag)});
        for (int i = 0; i < nsend; i++) exp_q.push_back({1'b0, mk_pay(tag, i)});
    endtask

    task automatic drain_cmp(input string name);
        int c;
        c = 0;
        while (c < 400 && got_q.size() < exp_q.size()) begin
            @(posedge clk);
            c++;
        end
        repeat (12) @(posedge clk);
        #1;
        chk({name, "_words"}, 80'(got_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_w%0d", name, i), 80'(got_q[i]), 80'(exp_q[i]));
        end
    endtask

    // ---------------- single-packet cycle table ----------------
    typedef struct {
        logic        stb;
        logic        sof;
        logic [71:0] data;
        logic        e_stb;
        logic        e_sof;
        logic [71:0] e_data;
        logic [1:0]  e_rdye;
    } vec_t;

    vec_t tv[10];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        int c;
        logic found;

        // header L=3 on lane 0, three payload words, then idle while it drains
        tv[0] = '{1'b1, 1'b1, mk_hdr(1'b0, 4'd3, 8'h11), 1'b0, 1'b0, 72'h0, 2'b10};
        tv[1] = '{1'b1, 1'b0, mk_pay(8'h11, 0),          1'b0, 1'b0, 72'h0, 2'b10};
        tv[2] = '{1'b1, 1'b0, mk_pay(8'h11, 1),          1'b0, 1'b0, 72'h0, 2'b10};
        tv[3] = '{1'b1, 1'b0, mk_pay(8'h11, 2),          1'b0, 1'b0, 72'h0, 2'b10};
        tv[4] = '{1'b0, 1'b0, 72'h0, 1'b0, 1'b0, 72'h0, 2'b10};
        tv[5] = '{1'b0, 1'b0, 72'h0, 1'b1, 1'b1, mk_hdr(1'b0, 4'd3, 8'h11), 2'b10};
        tv[6] = '{1'b0, 1'b0, 72'h0, 1'b1, 1'b0, mk_pay(8'h11, 0), 2'b10};
        tv[7] = '{1'b0, 1'b0, 72'h0, 1'b1, 1'b0, mk_pay(8'h11, 1), 2'b10};
        tv[8] = '{1'b0, 1'b0, 72'h0, 1'b1, 1'b0, mk_pay(8'h11, 2), 2'b11};
        tv[9] = '{1'b0, 1'b0, 72'h0, 1'b0, 1'b0, 72'h0, 2'b11};

        // ---- reset state ----
        o_rdy  = 2'b11;
        o_rdyE = 2'b00;
        do_reset();
        chk("rst_o_stb",  80'(o_stb),  80'(0));
        chk("rst_o_sof",  80'(o_sof),  80'(0));
        chk("rst_o_data", 80'(o_data), 80'(0));
        chk("rst_ff_err", 80'(ff_err), 80'(0));
        chk("rst_i_rdy",  80'(i_rdy),  80'(2'b11));
        chk("rst_i_rdyE", 80'(i_rdyE), 80'(2'b11));
        rst = 1'b1;

        // ---- 1: single lane-0 packet, cycle by cycle ----
        for (int i = 0; i < 10; i++) begin
            put(tv[i].stb, tv[i].sof, tv[i].data);
            chk($sformatf("s1_stb_%0d", i),  80'(o_stb),  80'(tv[i].e_stb));
            chk($sformatf("s1_sof_%0d", i),  80'(o_sof),  80'(tv[i].e_sof));
            if (tv[i].e_stb) chk($sformatf("s1_data_%0d", i), 80'(o_data), 80'(tv[i].e_data));
            chk($sformatf("s1_rdyE_%0d", i), 80'(i_rdyE), 80'(tv[i].e_rdye));
            chk($sformatf("s1_rdy_%0d", i),  80'(i_rdy),  80'(2'b11));
        end
        chk("s1_ff_err", 80'(ff_err), 80'(0));

        // ---- 2: fill lane 1 with three 9-word packets, downstream blocked ----
        o_rdy = 2'b00;
        do_reset();
        rst = 1'b1;
        send_pkt(1'b1, 4'd8, 8'h21, 8);
        send_pkt(1'b1, 4'd8, 8'h22, 8);
        chk("s2_rdy_after2",  80'(i_rdy),  80'(2'b11));
        chk("s2_rdyE_after2", 80'(i_rdyE), 80'(2'b01));
        send_pkt(1'b1, 4'd8, 8'h23, 8);
        chk("s2_rdy_after3",  80'(i_rdy),  80'(2'b01));
        repeat (6) @(posedge clk);
        #1;
        chk("s2_no_output", 80'(got_q.size()), 80'(0));
        exp_pkt(1'b1, 4'd8, 8'h21, 8);
        exp_pkt(1'b1, 4'd8, 8'h22, 8);
        exp_pkt(1'b1, 4'd8, 8'h23, 8);
        o_rdy = 2'b11;
        drain_cmp("s2");
        chk("s2_rdy_drained",  80'(i_rdy),  80'(2'b11));
        chk("s2_rdyE_drained", 80'(i_rdyE), 80'(2'b11));

        // ---- 3: two packets per lane, round-robin from lane 0 ----
        o_rdy  = 2'b00;
        o_rdyE = 2'b00;
        do_reset();
        rst = 1'b1;
        send_pkt(1'b0, 4'd2, 8'h31, 2);
        send_pkt(1'b0, 4'd4, 8'h33, 4);
        send_pkt(1'b1, 4'd1, 8'h32, 1);
        send_pkt(1'b1, 4'd0, 8'h34, 0);
        exp_pkt(1'b0, 4'd2, 8'h31, 2);
        exp_pkt(1'b1, 4'd1, 8'h32, 1);
        exp_pkt(1'b0, 4'd4, 8'h33, 4);
        exp_pkt(1'b1, 4'd0, 8'h34, 0);
        o_rdy = 2'b11;
        drain_cmp("s3");

        // ---- 4: same fill, downstream lane 1 empty so lane 1 goes first ----
        o_rdy  = 2'b00;
        o_rdyE = 2'b10;
        do_reset();
        rst = 1'b1;
        send_pkt(1'b0, 4'd2, 8'h41, 2);
        send_pkt(1'b0, 4'd4, 8'h43, 4);
        send_pkt(1'b1, 4'd1, 8'h42, 1);
        send_pkt(1'b1, 4'd0, 8'h44, 0);
        exp_pkt(1'b1, 4'd1, 8'h42, 1);
        exp_pkt(1'b1, 4'd0, 8'h44, 0);
        exp_pkt(1'b0, 4'd2, 8'h41, 2);
        exp_pkt(1'b0, 4'd4, 8'h43, 4);
        o_rdy = 2'b11;
        drain_cmp("s4");

        // ---- 5a: data word with no open packet ----
        o_rdy  = 2'b00;
        o_rdyE = 2'b00;
        do_reset();
        rst = 1'b1;
        put(1'b1, 1'b0, mk_pay(8'h50, 0));
        chk("s5a_ff_err", 80'(ff_err), 80'(1));
        chk("s5a_rdyE",   80'(i_rdyE), 80'(2'b11));

        // ---- 5b: truncation, including a zero-payload header closing one ----
        do_reset();
        rst = 1'b1;
        send_pkt(1'b0, 4'd5, 8'h55, 2);
        chk("s5b_err_clear", 80'(ff_err), 80'(0));
        send_pkt(1'b0, 4'd1, 8'h56, 1);
        chk("s5b_ff_err", 80'(ff_err), 80'(1));
        send_pkt(1'b1, 4'd3, 8'h57, 1);
        send_pkt(1'b1, 4'd0, 8'h58, 0);
        exp_pkt(1'b0, 4'd5, 8'h55, 2);
        exp_pkt(1'b1, 4'd3, 8'h57, 1);
        exp_pkt(1'b0, 4'd1, 8'h56, 1);
        exp_pkt(1'b1, 4'd0, 8'h58, 0);
        o_rdy = 2'b11;
        drain_cmp("s5b");

        // ---- 6: reset while a 5-word packet is being sent ----
        do_reset();
        rst = 1'b1;
        put(1'b1, 1'b0, mk_pay(8'h60, 0));
        chk("s6_err_set", 80'(ff_err), 80'(1));
        send_pkt(1'b0, 4'd4, 8'h61, 4);
        c = 0;
        found = 1'b0;
        while (c < 20 && !found) begin
            if (o_stb === 1'b1 && o_sof === 1'b1) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        chk("s6_sof_seen", 80'(found), 80'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_o_stb",  80'(o_stb),  80'(0));
        chk("s6_o_sof",  80'(o_sof),  80'(0));
        chk("s6_o_data", 80'(o_data), 80'(0));
        chk("s6_i_rdy",  80'(i_rdy),  80'(2'b11));
        chk("s6_i_rdyE", 80'(i_rdyE), 80'(2'b11));
        chk("s6_ff_err", 80'(ff_err), 80'(0));
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        repeat (12) @(posedge clk);
        #1;
        chk("s6_no_residue", 80'(got_q.size()), 80'(0));
        chk("s6_rdyE_idle",  80'(i_rdyE), 80'(2'b11));
        send_pkt(1'b1, 4'd2, 8'h62, 2);
        exp_pkt(1'b1, 4'd2, 8'h62, 2);
        drain_cmp("s6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rbus_pkt_fifo2ch.md
Name: rbus_pkt_fifo2ch

Overview:
- Two-lane store-and-forward packet buffer. It sits directly downstream of an N-to-1 rbus multiplexer output channel.
- Accepts rbus packets, sorts them into per-lane storage by the header lane bit, and advertises per-lane readiness upstream.
- Forwards only complete packets downstream, using packet-boundary arbitration between lanes.

Parameters:
DEPTH, 32, words of storage per lane (power of two, >= 2*MAX_PKT)
MAX_PKT, 9, maximum packet length in words (header + up to 8 payload)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
i_stb  in  1  input word valid
i_sof  in  1  input word is a packet header (qualified by i_stb)
i_data  in  72  input word; in a header, bit 71 = lane, bits 67:64 = payload word count L (0..8)
i_rdy  out  2  lane k can accept one full packet
i_rdyE  out  2  lane k storage completely empty
o_stb  out  1  output word valid
o_sof  out  1  output word is header
o_data  out  72  output word
o_rdy  in  2  downstream lane k can accept one full packet
o_rdyE  in  2  downstream lane k empty
ff_err  out  1  sticky protocol/overflow error

Behaviour:
- Reset is synchronous and active-low, on rst. The following hold while rst==0 at a clock edge:
  - o_stb=0, o_sof=0, o_data=0, ff_err=0.
  - All pointers and counters are 0.
  - i_rdy=2'b11, i_rdyE=2'b11.
  - Round-robin pointer selects lane 0.
  - All input-side and output-side packet state is discarded, including a partly received or partly sent packet.
- Input framing:
  - A header (i_stb & i_sof) latches the lane and the remaining count L.
  - Each following i_stb word decrements the count.
  - The packet is complete when the count reaches 0; a header with L=0 is complete immediately.
  - A complete packet increments the lane's pkt_cnt in the same cycle as its last write.
- Input errors (each sets ff_err):
  - stb without sof while no packet is open: the word is dropped.
  - sof while a packet is open: the open packet is truncated and committed as-is; the new header is accepted.
  - Write to a lane whose free space is 0: the word is dropped.
- Upstream readiness:
  - i_rdy[k] is registered. It is 1 iff free[k] >= MAX_PKT, computed after this cycle's write and read.
  - Upstream only starts a packet on lane k when i_rdy[k] was 1.
- i_rdyE[k] is registered. It is 1 iff word count of lane k == 0.
- Output FSM states:
  - IDLE:
    - Eligible lane k: pkt_cnt[k] > 0 and o_rdy[k] == 1.
    - Priority: an eligible lane with o_rdyE[k] == 1 wins; otherwise round-robin (lane after the last served); with a single eligible lane, that lane wins.
    - Go to SEND and latch the lane.
  - SEND:
    - One word per cycle: o_stb=1; o_sof=1 on the first word only.
    - Length is taken from the stored header; for a truncated packet the stored word count is used (a per-lane length side-FIFO holds the committed word count).
    - After the last word: decrement pkt_cnt, advance round-robin, return to IDLE. No bubble is required, but one idle cycle between packets is permitted.
  - A packet is never interrupted once SEND starts; o_rdy is sampled only in IDLE.
- Latency: last input word written at edge t; the earliest header output is registered at edge t+2.
- Simultaneous write and read on the same lane in one cycle are both performed; word count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; counters are log2(DEPTH)+1 bits.
- ff_err is sticky until reset.

Decomposition:
- Shared package rbus_pkg holds:
  - RBUS_W=72
  - RBUS_LANE_BIT=71
  - RBUS_LEN_LSB=64, RBUS_LEN_MSB=67
  - RBUS_MAX_PKT=9
  - typedef rbus_word_t (72-bit)
- One sub-module, rbus_lane_fifo: a single-lane word FIFO with a length side-FIFO, word/packet counters, and free-space output. It is instantiated twice, once per lane.
- Arbitration and the output FSM live in the top module.

Test Plan:
1. Reset, then one lane-0 packet (header L=3 + 3 words): i_rdyE drops to 2'b10 the cycle after the first write; o_sof appears 2 edges after the last word, followed by 4 consecutive o_stb words identical to the input; then i_rdyE returns to 2'b11.
2. Fill lane 1 with 3 packets of 9 words (27 words) while o_rdy=0: i_rdy[1] goes 0 after the 3rd packet (free 5 < 9); i_rdy[0] stays 1; no output occurs.
3. Both lanes hold 2 packets each, o_rdy=11, o_rdyE=00: output order is lane 0, 1, 0, 1 with whole packets and no interleaving within a packet.
4. Same as scenario 3 with o_rdyE=2'b10: lane 1 packets are served first while eligible.
5. Protocol errors:
   - i_stb=1, i_sof=0 with no open packet: ff_err=1 the next cycle, word dropped.
   - Header L=5, 2 words, then a new header: the first packet is output with 3 words, the second is intact.
6. Reset mid-SEND (rst=0 for one cycle during word 2 of 5): o_stb=0 the next cycle; all counts are 0, i_rdy=11, i_rdyE=11, ff_err=0.
